// File: rtl/spi_dac_pkg.sv
// Shared definitions for the DAC SPI link: frame size, command-word field
// positions and the receiver state encoding.
package spi_dac_pkg;

  localparam int FRAME_BITS = 16;

  localparam int DATA_MSB = 11;
  localparam int DATA_LSB = 2;
  localparam int CFG_MSB  = 15;
  localparam int CFG_LSB  = 12;

  localparam int DATA_W = DATA_MSB - DATA_LSB + 1;
  localparam int CFG_W  = CFG_MSB - CFG_LSB + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } rx_state_e;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser for one asynchronous input, plus a delay flop that
// yields single-cycle rise/fall pulses on the synchronised level.
module sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_n,
  input  logic din_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              dly_q;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      dly_q  <= RST_VAL;
    end else begin
      sync_q <= STAGES'({sync_q, din_i});
      dly_q  <= sync_q[STAGES-1];
    end
  end

  assign lvl_o  = sync_q[STAGES-1];
  assign rise_o = sync_q[STAGES-1] & ~dly_q;
  assign fall_o = ~sync_q[STAGES-1] & dly_q;

endmodule

// File: rtl/spi2dac_rx.sv
// Oversampling SPI responder for MCP4911-format DAC words: shifts a frame on
// sck, holds a complete word, and presents sample/config on the ld_n strobe.
module spi2dac_rx #(
  parameter int FRAME_BITS  = spi_dac_pkg::FRAME_BITS,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          sysclk,
  input  logic                          rst_n,
  input  logic                          sck,
  input  logic                          cs_n,
  input  logic                          sdi,
  input  logic                          ld_n,
  output logic [spi_dac_pkg::DATA_W-1:0] data_out,
  output logic [spi_dac_pkg::CFG_W-1:0]  cfg_out,
  output logic                          data_valid,
  output logic                          frame_err,
  output logic                          held
);

  import spi_dac_pkg::*;

  localparam int             CW       = $clog2(FRAME_BITS + 2);
  localparam logic [CW-1:0]  CNT_FULL = CW'(FRAME_BITS);
  localparam logic [CW-1:0]  CNT_SAT  = CW'(FRAME_BITS + 1);

  logic sck_lvl, sck_rise, sck_fall;
  logic cs_lvl,  cs_rise,  cs_fall;
  logic sdi_lvl, sdi_rise, sdi_fall;
  logic ld_lvl,  ld_rise,  ld_fall;

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk_i(sysclk), .rst_n(rst_n), .din_i(sck),
    .lvl_o(sck_lvl), .rise_o(sck_rise), .fall_o(sck_fall)
  );
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk_i(sysclk), .rst_n(rst_n), .din_i(cs_n),
    .lvl_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall)
  );
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sdi (
    .clk_i(sysclk), .rst_n(rst_n), .din_i(sdi),
    .lvl_o(sdi_lvl), .rise_o(sdi_rise), .fall_o(sdi_fall)
  );
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ld (
    .clk_i(sysclk), .rst_n(rst_n), .din_i(ld_n),
    .lvl_o(ld_lvl), .rise_o(ld_rise), .fall_o(ld_fall)
  );

  rx_state_e               state_q;
  logic [FRAME_BITS-1:0]   shreg_q;
  logic [FRAME_BITS-1:0]   hold_q;
  logic [CW-1:0]           bitcnt_q;
  logic [DATA_W-1:0]       data_q;
  logic [CFG_W-1:0]        cfg_q;
  logic                    valid_q;
  logic                    err_q;
  logic                    held_q;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      hold_q   <= '0;
      bitcnt_q <= '0;
      data_q   <= '0;
      cfg_q    <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      held_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cs_fall) begin
            shreg_q  <= '0;
            bitcnt_q <= '0;
            state_q  <= SHIFT;
          end
        end
        SHIFT: begin
          // Frame end outranks a coincident sck edge.
          if (cs_rise) begin
            if (bitcnt_q == CNT_FULL) begin
              hold_q  <= shreg_q;
              err_q   <= 1'b0;
              held_q  <= 1'b1;
              state_q <= HOLD;
            end else begin
              err_q   <= 1'b1;
              held_q  <= 1'b0;
              state_q <= IDLE;
            end
          end else if (sck_rise && !cs_lvl) begin
            shreg_q <= {shreg_q[FRAME_BITS-2:0], sdi_lvl};
            if (bitcnt_q != CNT_SAT) begin
              bitcnt_q <= bitcnt_q + CW'(1);
            end
          end
        end
        HOLD: begin
          if (ld_fall) begin
            data_q  <= hold_q[DATA_MSB:DATA_LSB];
            cfg_q   <= hold_q[CFG_MSB:CFG_LSB];
            valid_q <= 1'b1;
            held_q  <= 1'b0;
            state_q <= cs_fall ? SHIFT : IDLE;
          end else begin
            state_q <= cs_fall ? SHIFT : HOLD;
          end
          if (cs_fall) begin
            shreg_q  <= '0;
            bitcnt_q <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_out   = data_q;
  assign cfg_out    = cfg_q;
  assign data_valid = valid_q;
  assign frame_err  = err_q;
  assign held       = held_q;

  logic edges_unused;
  assign edges_unused = sck_lvl ^ sck_fall ^ sdi_rise ^ sdi_fall ^ ld_lvl ^ ld_rise
                        ^ (^hold_q[DATA_LSB-1:0]);

endmodule

// File: tb/tb_spi2dac_rx.sv
// Randomised bench for spi2dac_rx: a frame-level model predicts loads into a
// scoreboard queue, and a monitor checks every data_valid pulse and output hold.
module tb_spi2dac_rx;

  logic       sysclk = 1'b0;
  logic       rst_n  = 1'b0;
  logic       sck    = 1'b0;
  logic       cs_n   = 1'b1;
  logic       sdi    = 1'b1;
  logic       ld_n   = 1'b1;
  logic [9:0] data_out;
  logic [3:0] cfg_out;
  logic       data_valid, frame_err, held;

  spi2dac_rx dut (
    .sysclk(sysclk), .rst_n(rst_n), .sck(sck), .cs_n(cs_n), .sdi(sdi), .ld_n(ld_n),
    .data_out(data_out), .cfg_out(cfg_out), .data_valid(data_valid),
    .frame_err(frame_err), .held(held)
  );

  always #10 sysclk = ~sysclk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  typedef struct {
    logic [9:0] d;
    logic [3:0] c;
    int         cy;
  } exp_t;
  exp_t exp_q[$];

  // Frame-level model of the receiver
  bit          m_hold_valid = 0;
  bit          m_err        = 0;
  bit          m_in_frame   = 0;
  logic [15:0] m_hold_word  = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic [9:0] last_d = '0;
  logic [3:0] last_c = '0;
  always @(negedge sysclk) begin : monitor
    exp_t e;
    if (!rst_n) begin
      last_d = '0;
      last_c = '0;
    end else if (data_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: data_out 0x%0h cfg_out 0x%0h, expected no pulse (cycle %0d)",
                 data_out, cfg_out, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("data_out", 32'(data_out), 32'(e.d));
        chk("cfg_out", 32'(cfg_out), 32'(e.c));
        chk("valid_cycle", 32'(cyc), 32'(e.cy));
      end
      last_d = data_out;
      last_c = cfg_out;
    end else begin
      chk("data_stable", 32'(data_out), 32'(last_d));
      chk("cfg_stable", 32'(cfg_out), 32'(last_c));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic send_frame(input int nbits, input logic [31:0] bits, input int h, input bit mis_ld);
    tick(1);
    cs_n = 1'b0;
    m_in_frame = 1;
    tick(h);
    for (int i = nbits - 1; i >= 0; i--) begin
      sdi = bits[i];
      tick(h);
      sck = 1'b1;
      if (mis_ld && i == nbits / 2) ld_n = 1'b0;
      tick(h);
      sck  = 1'b0;
      ld_n = 1'b1;
    end
    tick(h);
    cs_n = 1'b1;
    m_in_frame = 0;
    if (nbits == 16) begin
      m_hold_valid = 1;
      m_hold_word  = bits[15:0];
      m_err        = 0;
    end else begin
      m_hold_valid = 0;
      m_err        = 1;
    end
    tick(6);
    chk("frame_err", 32'(frame_err), 32'(m_err));
    chk("held", 32'(held), 32'(m_hold_valid));
  endtask

  task automatic pulse_ld();
    exp_t e;
    ld_n = 1'b0;
    if (m_hold_valid && !m_in_frame) begin
      e.d  = m_hold_word[11:2];
      e.c  = m_hold_word[15:12];
      e.cy = cyc + 3;
      exp_q.push_back(e);
      m_hold_valid = 0;
    end
    tick(5);
    ld_n = 1'b1;
    tick(5);
    chk("held_after_ld", 32'(held), 32'(m_hold_valid));
    chk("err_after_ld", 32'(frame_err), 32'(m_err));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_data"}, 32'(data_out), 32'd0);
    chk({tag, "_cfg"}, 32'(cfg_out), 32'd0);
    chk({tag, "_valid"}, 32'(data_valid), 32'd0);
    chk({tag, "_err"}, 32'(frame_err), 32'd0);
    chk({tag, "_held"}, 32'(held), 32'd0);
  endtask

  task automatic reset_mid_frame(input logic [15:0] w, input int h);
    tick(1);
    cs_n = 1'b0;
    tick(h);
    for (int i = 15; i >= 8; i--) begin
      sdi = w[i];
      tick(h);
      sck = 1'b1;
      tick(h);
      sck = 1'b0;
    end
    rst_n = 1'b0;
    tick(2);
    check_all_zero("rst_mid");
    cs_n = 1'b1;
    sck  = 1'b0;
    sdi  = 1'b1;
    ld_n = 1'b1;
    m_hold_valid = 0;
    m_err        = 0;
    m_in_frame   = 0;
    tick(3);
    rst_n = 1'b1;
    tick(8);
    check_all_zero("post_rst");
  endtask

  initial begin
    #5_000_000;
    errors++;
    $display("FAIL watchdog: simulation still running at cycle %0d, expected to have finished", cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    int r, h, n;
    logic [31:0] w;
    rst_n = 1'b0;
    tick(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    tick(5);
    check_all_zero("idle");

    // Good frame at 1 MHz sck, then load
    send_frame(16, 32'h3AAC, 25, 0);
    pulse_ld();
    // Short frame: error, and a load does nothing
    send_frame(15, 32'h1D56, 25, 0);
    pulse_ld();
    // Long frame, then a good frame clears the error
    send_frame(18, 32'h2F004, 25, 0);
    send_frame(16, 32'hF004, 25, 0);
    pulse_ld();
    // Load during a frame and in idle
    send_frame(16, 32'h1234, 25, 1);
    pulse_ld();
    pulse_ld();
    // Overwrite a held word before loading
    send_frame(16, 32'h3AAC, 25, 0);
    send_frame(16, 32'h3FFC, 25, 0);
    pulse_ld();
    // Reset mid-frame, then recover
    reset_mid_frame(16'hA5A5, 25);
    send_frame(16, 32'h5A5C, 25, 0);
    pulse_ld();

    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 4);
      h = $urandom_range(3, 8);
      w = $urandom;
      case (r)
        0, 1: begin
          send_frame(16, w, h, bit'($urandom_range(0, 1)));
          if ($urandom_range(0, 1) == 1) pulse_ld();
        end
        2: begin
          n = $urandom_range(1, 15);
          send_frame(n, w, h, bit'($urandom_range(0, 1)));
        end
        3: begin
          n = $urandom_range(17, 20);
          send_frame(n, w, h, 0);
        end
        default: pulse_ld();
      endcase
    end
    pulse_ld();

    tick(10);
    chk("pending_loads", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi2dac_rx.md
# spi2dac_rx

Serial-to-parallel receiver for the DAC SPI link: the responder side of `spi2dac`. It oversamples `DAC_SCK`, `DAC_CS`, `DAC_SDI` and `DAC_LD` on the 50 MHz system clock and decodes each 16-bit MCP4911-format command word. When the load strobe arrives, it presents the 10-bit sample and the 4 configuration bits as parallel outputs. It is used as an on-chip loopback monitor and as the DAC model in the audio-path testbenches.

## Interface
- `FRAME_BITS`, default 16: bits per valid command word.
- `SYNC_STAGES`, default 2: synchroniser depth on each serial input.
- `sysclk`  in  1  50 MHz system clock.
- `rst_n`  in  1  reset; asynchronous assert, active-low, synchronous release assumed upstream.
- `sck`  in  1  serial clock from the initiator; data is sampled on its rising edge.
- `cs_n`  in  1  chip select, active-low; frames a word.
- `sdi`  in  1  serial data, MSB first.
- `ld_n`  in  1  load strobe, active-low; transfers the held word to the outputs.
- `data_out`  out  10  last loaded DAC sample (word bits 11:2).
- `cfg_out`  out  4  last loaded config {A/B̄, BUF, GĀ, SHDN̄} (word bits 15:12).
- `data_valid`  out  1  one-`sysclk` pulse when `data_out`/`cfg_out` update.
- `frame_err`  out  1  sticky; set on a malformed frame, cleared by the next good frame.
- `held`  out  1  a complete word is latched and awaiting `ld_n`.

## Operation
- Each serial input passes through a `SYNC_STAGES`-flop synchroniser plus one delay flop for edge detection. All decisions use the synchronised versions only.
- **State IDLE**
  - Waits for a `cs_n` falling edge.
  - On that edge: clear `shreg` (16 bits) and `bitcnt` (5 bits), then go to SHIFT.
- **State SHIFT**
  - On each `sck` rising edge with `cs_n` low: `shreg <= {shreg[14:0], sdi}`, and `bitcnt` increments, saturating at 17.
  - On a `cs_n` rising edge with `bitcnt == 16`: copy `shreg` to `hold_reg`, clear `frame_err`, go to HOLD.
  - On a `cs_n` rising edge with `bitcnt != 16`: set `frame_err`, discard the word, go to IDLE. Any previous `hold_reg` is also discarded and `held` drops.
- **State HOLD**
  - `held = 1`.
  - On an `ld_n` falling edge: `data_out <= hold_reg[11:2]`, `cfg_out <= hold_reg[15:12]`, pulse `data_valid`, go to IDLE.
  - On a `cs_n` falling edge before `ld_n`: the new frame overwrites. Go to SHIFT; `hold_reg` is kept until the new frame completes.
- `ld_n` falling in IDLE or SHIFT has no effect on the outputs and does not flag an error.
- If `sck` rising and `cs_n` rising are detected in the same cycle, the `cs_n` edge wins and the clock edge is ignored.
- Word bits 1:0 are ignored.
- **Reset values:** `data_out = 0`, `cfg_out = 0`, `data_valid = 0`, `frame_err = 0`, `held = 0`, state IDLE, all synchronisers 1 except `sck` (0). Asserting reset mid-frame aborts the frame with no output change after release.

## Timing
- Input-pin edge to internal action takes `SYNC_STAGES` + 1 `sysclk` edges. With the default depth, outputs update on the 3rd `sysclk` rising edge after the `ld_n` pin falls.
- `data_valid` is high for exactly one cycle, coincident with the first cycle the new `data_out` is visible.
- `held` rises 3 cycles after the `cs_n` pin rises on a good frame. It falls in the same cycle `data_valid` pulses.
- Input constraints:
  - `sck` high and low each ≥ `SYNC_STAGES` + 1 `sysclk` cycles.
  - `sdi` stable ≥ 1 cycle either side of the `sck` rising edge.
  - `cs_n` high ≥ 3 cycles between frames.
- Throughput: one word per `cs_n` frame; there is no backpressure.

## Structure
- Shared package `spi_dac_pkg`:
  - `FRAME_BITS`.
  - Field positions `DATA_MSB = 11`, `DATA_LSB = 2`, `CFG_MSB = 15`, `CFG_LSB = 12`.
  - The state enum {IDLE, SHIFT, HOLD}.
- Sub-module `sync_edge`: parameterised synchroniser with `rise`/`fall` pulse outputs, instantiated once per serial input.

## Test plan
- **Good frame:** word 0x3AAC (`cfg` 0011, data 0x2AB) shifted at 1 MHz `sck`, then `cs_n` high, then `ld_n` low. Expect `held` = 1, then `data_valid` pulse with `data_out` = 0x2AB and `cfg_out` = 0x3 three cycles after the `ld_n` fall; `frame_err` = 0.
- **Short frame:** 15 bits, then `cs_n` high. Expect `frame_err` = 1, `held` = 0. A following `ld_n` pulse produces no `data_valid`; outputs keep their previous values.
- **Long frame:** 18 bits. Expect `frame_err` = 1. A subsequent good frame 0xF004 clears `frame_err`; after `ld_n`, `data_out` = 0x001 and `cfg_out` = 0xF.
- **Misplaced loads:** `ld_n` low while `cs_n` is low, and `ld_n` in IDLE. Expect no `data_valid` and no output change.
- **Overwrite:** good frame A (0x3AAC) held, then frame B (0x3FFC) sent with no `ld_n` in between, then `ld_n`. Expect a single `data_valid` with `data_out` = 0x3FF.
- **Reset mid-frame:** `rst_n` low after 8 bits, then released. Expect all outputs 0, state IDLE, and the next good frame decoded correctly.
